// File: rtl/watch_pkg.sv
// Shared constants for the watch display path: active-low segment patterns {g,f,e,d,c,b,a}
// and the scan FSM state encoding.
package watch_pkg;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
    import watch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame snapshot, leading-zero blanking and
// lap hold. Define DIGIT_BLINK_EN to build the per-digit blink feature.
module seg_scan_driver
    import watch_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned BLINK_DIV  = 12500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    hold,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_sel,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned PresW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PresW-1:0] PresLast  = PresW'(SCAN_DIV - 1);
    localparam logic [PresW-1:0] GuardLast = PresW'(GUARD - 1);
    localparam logic [IdxW-1:0]  IdxLast   = IdxW'(NUM_DIGITS - 1);

    logic [PresW-1:0]        pres_q, pres_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    state_e                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0] lz_blank, an_sel;
    logic                  upper_zero;
    logic [3:0]            cur_digit;
    logic                  cur_lz, cur_dp, cur_blink, blink_off;
    logic [6:0]            dec_seg;

    // lz_blank[i]: digit i and everything above it are zero; digit 0 is never blanked.
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero  = upper_zero & (snap_q[4*i +: 4] == 4'd0);
            lz_blank[i] = upper_zero;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_lz    = 1'b0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_digit = snap_q[4*i +: 4];
                cur_lz    = lz_blank[i];
                cur_dp    = dp_mask[i];
                cur_blink = blink_sel[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef DIGIT_BLINK_EN
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_off = phase_q & cur_blink;
`else
    logic unused_blink;
    assign unused_blink = cur_blink;
    assign blink_off    = 1'b0;
`endif

    always_comb begin
        pres_d = (pres_q == PresLast) ? '0 : pres_q + PresW'(1);
        idx_d  = idx_q;
        if (pres_q == PresLast) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end

        state_d = state_q;
        if (state_q == S_GUARD && pres_q == GuardLast) begin
            state_d = S_DRIVE;
        end else if (pres_q == PresLast) begin
            state_d = S_GUARD;
        end

        // Snapshot only at frame start so a frame never mixes old and new digits.
        snap_d = (idx_q == '0 && pres_q == '0 && !hold) ? digits : snap_q;

        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        an_d         = '1;
        frame_done_d = (idx_q == IdxLast) && (pres_q == PresLast);
        if (state_q == S_DRIVE) begin
            an_d  = an_sel;
            dp_d  = ~cur_dp;
            seg_d = (blank_lz && cur_lz) ? SEG_OFF : dec_seg;
            if (blink_off) begin
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pres_q       <= '0;
            idx_q        <= '0;
            state_q      <= S_GUARD;
            snap_q       <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            pres_q       <= pres_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            snap_q       <= snap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle model predicts every registered output.
module tb_seg_scan_driver;

    localparam int unsigned N  = 6;
    localparam int unsigned SD = 4;
    localparam int unsigned G  = 1;
    localparam int unsigned BD = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [4*N-1:0] digits;
    logic           hold;
    logic           blank_lz;
    logic [N-1:0]   dp_mask;
    logic [N-1:0]   blink_sel;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   an;
    logic           frame_done;

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .GUARD      (G),
        .BLINK_DIV  (BD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .hold       (hold),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
        .blink_sel  (blink_sel),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         fd;
    } out_t;

    out_t exp_q[$];
    int total = 0;
    int bad = 0;

    int             m_pres, m_idx, m_bcnt, cyc, last_fd;
    logic [4*N-1:0] m_snap;
    logic           m_phase;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d > 4'd9) ? 7'h3F : tbl[d];
    endfunction

    task automatic model_reset();
        m_pres  = 0;
        m_idx   = 0;
        m_bcnt  = 0;
        m_phase = 1'b0;
        m_snap  = '0;
        last_fd = -1;
        exp_q.delete();
    endtask

    // Predict the outputs after the coming edge from the current model state and live inputs.
    task automatic model_push();
        out_t         e;
        logic [N-1:0] one;
        logic [3:0]   d;
        one   = 1;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.an  = '1;
        e.fd  = (m_idx == N - 1) && (m_pres == SD - 1);
        if (m_pres >= G) begin
            e.an  = ~(one << m_idx);
            d     = m_snap[4*m_idx +: 4];
            e.seg = seg_ref(d);
            if (blank_lz && m_idx != 0 && (m_snap >> (4 * m_idx)) == 0) e.seg = 7'h7F;
            e.dp = ~dp_mask[m_idx];
`ifdef DIGIT_BLINK_EN
            if (m_phase && blink_sel[m_idx]) begin
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end
`endif
        end
        exp_q.push_back(e);
        if (m_idx == 0 && m_pres == 0 && !hold) m_snap = digits;
        m_pres++;
        if (m_pres == SD) begin
            m_pres = 0;
            m_idx  = (m_idx + 1) % N;
        end
        m_bcnt++;
        if (m_bcnt == BD) begin
            m_bcnt  = 0;
            m_phase = ~m_phase;
        end
    endtask

    task automatic step();
        out_t e;
        model_push();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("seg", 32'(seg), 32'(e.seg));
        check_eq("dp", 32'(dp), 32'(e.dp));
        check_eq("an", 32'(an), 32'(e.an));
        check_eq("frame_done", 32'(frame_done), 32'(e.fd));
        if (frame_done) begin
            if (last_fd >= 0) check_eq("fd_period", 32'(cyc - last_fd), 32'(N * SD));
            last_fd = cyc;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit found;
        reset     = 1'b1;
        digits    = 24'h012345;
        hold      = 1'b0;
        blank_lz  = 1'b0;
        dp_mask   = '0;
        blink_sel = '0;
        cyc       = 0;
        model_reset();
        #1 reset = 1'b0;
        #22;
        check_eq("rst_seg", 32'(seg), 32'h7F);
        check_eq("rst_dp", 32'(dp), 32'h1);
        check_eq("rst_an", 32'(an), 32'h3F);
        check_eq("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk) reset = 1'b1;

        run(60);

        blank_lz = 1'b1;
        digits   = 24'h000070;
        run(48);

        digits = 24'h000000;
        run(48);

        blank_lz = 1'b0;
        digits   = 24'h012345;
        run(30);
        for (int i = 0; i < 30 && m_idx != 2; i++) step();
        hold   = 1'b1;
        digits = 24'h999999;
        run(40);
        hold  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            found = frame_done;
        end
        check_eq("fd_seen", 32'(found), 32'h1);
        run(2);
        check_eq("hold_new_seg", 32'(seg), 32'h10);
        check_eq("hold_new_an", 32'(an), 32'h3E);

        digits  = 24'h00000C;
        dp_mask = 6'b000001;
        run(30);

        dp_mask   = '0;
        blink_sel = 6'b000001;
        run(48);

        #2 reset = 1'b0;
        #1;
        check_eq("async_an", 32'(an), 32'h3F);
        check_eq("async_seg", 32'(seg), 32'h7F);
        check_eq("async_dp", 32'(dp), 32'h1);
        check_eq("async_fd", 32'(frame_done), 32'h0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        blink_sel = '0;
        digits    = 24'h543210;
        run(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment display driver for the watch/stopwatch controller. Sits directly downstream of the Mod6/Mod10 digit counter chain and consumes their 4-bit digit values. Each frame it snapshots the digit bus, scans one digit per slot with an anti-ghost guard interval, and decodes BCD to active-low segments. It supports leading-zero blanking, per-digit decimal points and a lap hold.

## Interface
- NUM_DIGITS, 6, number of digits/anodes; digit 0 is least significant (rightmost).
- SCAN_DIV, 50000, clk cycles per digit slot; ≥ GUARD+1.
- GUARD, 2, cycles at the start of each slot with all anodes off; ≥ 1.
- BLINK_DIV, 12500000, clk cycles per blink half-period; used only when DIGIT_BLINK_EN is defined.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  digit i at [4i+3:4i], from the counter chain.
- hold  in  1  1 = freeze the displayed snapshot (lap).
- blank_lz  in  1  1 = blank leading zeros.
- dp_mask  in  NUM_DIGITS  1 = light the decimal point of digit i.
- blink_sel  in  NUM_DIGITS  1 = digit i blinks; ignored without DIGIT_BLINK_EN.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- an  out  NUM_DIGITS  active-low one-hot anode select.
- frame_done  out  1  one-cycle pulse at each frame start.

## Operation
- Reset values:
  - seg=7'h7F, dp=1, an=all 1s, frame_done=0.
  - idx=0, pres=0, state=S_GUARD, snapshot=0, blink phase=0.
- Prescaler pres counts 0..SCAN_DIV-1 and wraps. At wrap, idx advances; idx wraps from NUM_DIGITS-1 to 0.
- FSM:
  - S_GUARD (pres < GUARD): an all 1s, seg 7'h7F, dp 1. Moves to S_DRIVE when pres==GUARD-1.
  - S_DRIVE: an[idx]=0, others 1. Returns to S_GUARD at pres wrap.
- Snapshot: loads digits on any cycle with idx==0, pres==0 and hold==0. With hold==1, the previous snapshot is kept, so display updates never tear mid-frame. The first cycle after reset release loads the snapshot if hold==0.
- Decode:
  - 0–9: standard patterns.
  - 10–15: dash, g only (seg=7'h3F).
- Leading-zero blanking (blank_lz=1): digit i is blanked when snapshot digit i and every higher digit are 0. Digit 0 is never blanked. A blanked digit still drives its anode, with seg=7'h7F; dp still follows dp_mask.
- dp = ~dp_mask[idx] in S_DRIVE.
- frame_done is set at the edge where idx==NUM_DIGITS-1 and pres==SCAN_DIV-1, so it is high for the first cycle of the next frame.
- hold, blank_lz, dp_mask and blink_sel are sampled live; they take effect on the next registered output update.

## Timing
- All outputs are registered; each output reflects the state/pres/idx values of the previous cycle (1-cycle latency).
- Slot = SCAN_DIV cycles: GUARD blank cycles followed by SCAN_DIV-GUARD driven cycles.
- Frame = NUM_DIGITS*SCAN_DIV cycles.
- Reset asserted mid-slot: outputs go immediately (asynchronously) to their reset values. Scanning restarts at digit 0 with a guard interval.
- A digits change while hold==0 becomes visible only from the next frame start.

## Configuration
- DIGIT_BLINK_EN defined:
  - A BLINK_DIV counter toggles the blink phase.
  - While phase==1, the slot of any digit with blink_sel[idx]=1 outputs seg=7'h7F and dp=1, with its anode still asserted.
  - The blink counter resets to 0 with phase 0.
- DIGIT_BLINK_EN undefined: no blink counter is built and blink_sel is ignored. The port remains present.

## Structure
- Shared package watch_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - state encodings S_GUARD and S_DRIVE.
- One combinational sub-module, bcd_to_seg (4-bit in, 7-bit active-low out), instantiated once on the muxed snapshot digit.

## Test plan
Parameters for all scenarios: NUM_DIGITS=6, SCAN_DIV=4, GUARD=1, BLINK_DIV=8.
- Reset, then digits=0x012345, hold=0, blank_lz=0:
  - an walks 111110 → 111101 → … → 011111, each slot 1 blank cycle then 3 driven cycles.
  - Digit 0 shows SEG_5 (7'h12).
  - frame_done pulses every 24 cycles.
- blank_lz=1, digits=0x000070: digits 5..2 show 7'h7F; digit 1 shows SEG_7; digit 0 shows SEG_0.
- digits=0x000000, blank_lz=1: only digit 0 lit, showing SEG_0 (7'h40).
- hold=1, then digits changed to 0x999999 mid-frame: the display keeps the old value. After hold=0, the new value appears at the next frame start, coincident with frame_done.
- Digit value 4'hC with dp_mask[0]=1: seg=7'h3F and dp=0 during digit 0's driven cycles.
- With DIGIT_BLINK_EN, blink_sel=000001: digit 0 is dark for 8 cycles and lit for 8 cycles, alternating. Reset asserted mid-slot gives an=all 1s in the same cycle.
